// File: rtl/cordic_phase_driver.sv
// NCO-driven angle issuer for a rotation-mode CORDIC core, with credit-based flow control
// and a show-ahead result FIFO toward the downstream datapath.
module cordic_phase_driver #(
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ENABLE,
  input  logic [PHASE_W-1:0]            FREQ_WORD,
  input  logic                          FREQ_LOAD,
  input  logic [PHASE_W-1:0]            PHASE_OFFSET,
  input  logic                          PHASE_CLR,
  output logic [PHASE_W-1:0]            CORD_DIN_A,
  output logic                          CORD_DIN_VALID,
  input  logic                          CORD_RFD,
  input  logic                          CORD_DOUT_VALID,
  input  logic [OUT_W-1:0]              CORD_DOUT_X,
  input  logic [OUT_W-1:0]              CORD_DOUT_Y,
  output logic [OUT_W-1:0]              OUT_COS,
  output logic [OUT_W-1:0]              OUT_SIN,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [$clog2(FIFO_DEPTH):0]   INFLIGHT,
  output logic                          DRAINED,
  output logic                          ERR
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PHASE_W-1:0] freq_q;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] ang_q;
  logic               en_q;

  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W:0]     occupied;
  logic               err_q, err_d;

  logic [OUT_W-1:0]   cos_mem [FIFO_DEPTH];
  logic [OUT_W-1:0]   sin_mem [FIFO_DEPTH];

  logic               issue;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Every queued entry and every angle inside the core holds one FIFO slot in reserve.
  assign occupied = {1'b0, count_q} + {1'b0, inflight_q};
  assign issue    = en_q & CORD_RFD & (occupied < (CNT_W + 1)'(FIFO_DEPTH));

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = CORD_DOUT_VALID & ~full;
  assign pop   = ~empty & OUT_READY;

  // ang_q is built from the next accumulator value so back-to-back issues see fresh phases.
  always_comb begin
    acc_d = acc_q;
    if (PHASE_CLR) begin
      acc_d = '0;
    end else if (issue) begin
      acc_d = acc_q + freq_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      freq_q <= '0;
      acc_q  <= '0;
      ang_q  <= '0;
      en_q   <= 1'b0;
    end else begin
      if (FREQ_LOAD) begin
        freq_q <= FREQ_WORD;
      end
      acc_q <= acc_d;
      ang_q <= acc_d + PHASE_OFFSET;
      en_q  <= ENABLE;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, CORD_DOUT_VALID})
      2'b10: inflight_d = inflight_q + CNT_W'(1);
      2'b01: begin
        if (inflight_q != '0) begin
          inflight_d = inflight_q - CNT_W'(1);
        end
      end
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // A result with nothing outstanding, or one arriving with no room, means the core misbehaved.
  always_comb begin
    err_d = err_q;
    if (CORD_DOUT_VALID && ((inflight_q == '0) || full)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      err_q      <= err_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      cos_mem[wr_ptr_q] <= CORD_DOUT_X;
      sin_mem[wr_ptr_q] <= CORD_DOUT_Y;
    end
  end

  // Head is forced to zero when empty so the storage array needs no reset.
  always_comb begin
    OUT_COS = '0;
    OUT_SIN = '0;
    if (!empty) begin
      OUT_COS = cos_mem[rd_ptr_q];
      OUT_SIN = sin_mem[rd_ptr_q];
    end
  end

  assign CORD_DIN_A     = ang_q;
  assign CORD_DIN_VALID = issue;
  assign OUT_VALID      = ~empty;
  assign INFLIGHT       = inflight_q;
  assign DRAINED        = (inflight_q == '0) && empty;
  assign ERR            = err_q;

endmodule

// File: tb/tb_cordic_phase_driver.sv
// Bench for cordic_phase_driver: an ideal fixed-latency CORDIC core model plus an NCO
// reference (angle_k = offset + k*freq) and an in-order result reference.
module tb_cordic_phase_driver;

  localparam int unsigned PW = 32;
  localparam int unsigned OW = 32;
  localparam int unsigned FD = 16;

  logic          CLK, RST, ENABLE, FREQ_LOAD, PHASE_CLR;
  logic [PW-1:0] FREQ_WORD, PHASE_OFFSET, CORD_DIN_A;
  logic          CORD_DIN_VALID, CORD_RFD, CORD_DOUT_VALID;
  logic [OW-1:0] CORD_DOUT_X, CORD_DOUT_Y, OUT_COS, OUT_SIN;
  logic          OUT_VALID, OUT_READY, DRAINED, ERR;
  logic [4:0]    INFLIGHT;

  cordic_phase_driver #(.PHASE_W(PW), .OUT_W(OW), .FIFO_DEPTH(FD)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .FREQ_WORD(FREQ_WORD), .FREQ_LOAD(FREQ_LOAD),
    .PHASE_OFFSET(PHASE_OFFSET), .PHASE_CLR(PHASE_CLR), .CORD_DIN_A(CORD_DIN_A),
    .CORD_DIN_VALID(CORD_DIN_VALID), .CORD_RFD(CORD_RFD), .CORD_DOUT_VALID(CORD_DOUT_VALID),
    .CORD_DOUT_X(CORD_DOUT_X), .CORD_DOUT_Y(CORD_DOUT_Y), .OUT_COS(OUT_COS), .OUT_SIN(OUT_SIN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .INFLIGHT(INFLIGHT), .DRAINED(DRAINED),
    .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int          due;
    logic [31:0] x;
    logic [31:0] y;
  } core_t;

  core_t       core_q[$];
  logic [31:0] iss_ang[$];
  int          iss_cyc[$];
  logic [31:0] got_c[$];
  logic [31:0] got_s[$];
  int          pop_cyc[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat = 4;
  int   returned = 0;
  int   rfd_mode = 0;
  int   rdy_mode = 1;
  bit   rfd_man = 1'b0;
  bit   inj = 1'b0;

  function automatic logic [31:0] rnd(real v);
    return 32'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
  endfunction

  function automatic logic [31:0] cosv(logic [31:0] a);
    real r;
    r = $itor($signed(a)) * 3.141592653589793 / 2147483648.0;
    return rnd($cos(r) * 1073741823.0);
  endfunction

  function automatic logic [31:0] sinv(logic [31:0] a);
    real r;
    r = $itor($signed(a)) * 3.141592653589793 / 2147483648.0;
    return rnd($sin(r) * 1073741823.0);
  endfunction

  function automatic logic [31:0] nco(logic [31:0] off, logic [31:0] f, int k);
    return off + f * 32'(k);
  endfunction

  // One clock edge: drive core/sink inputs, sample handshakes just before the edge.
  task automatic cycle();
    if (inj) begin
      CORD_DOUT_VALID = 1'b1;
      CORD_DOUT_X     = 32'h1234_5678;
      CORD_DOUT_Y     = 32'h9abc_def0;
    end else if (core_q.size() > 0 && core_q[0].due == cyc) begin
      CORD_DOUT_VALID = 1'b1;
      CORD_DOUT_X     = core_q[0].x;
      CORD_DOUT_Y     = core_q[0].y;
      void'(core_q.pop_front());
      returned++;
    end else begin
      CORD_DOUT_VALID = 1'b0;
      CORD_DOUT_X     = '0;
      CORD_DOUT_Y     = '0;
    end
    case (rfd_mode)
      0:       CORD_RFD = 1'b1;
      1:       CORD_RFD = (cyc % 4 == 0);
      default: CORD_RFD = rfd_man;
    endcase
    case (rdy_mode)
      0:       OUT_READY = 1'b0;
      1:       OUT_READY = 1'b1;
      default: OUT_READY = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (CORD_DIN_VALID === 1'b1) begin
      iss_ang.push_back(CORD_DIN_A);
      iss_cyc.push_back(cyc);
      core_q.push_back('{due: cyc + lat, x: cosv(CORD_DIN_A), y: sinv(CORD_DIN_A)});
    end
    if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
      got_c.push_back(OUT_COS);
      got_s.push_back(OUT_SIN);
      pop_cyc.push_back(cyc);
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic clear_logs();
    core_q.delete();
    iss_ang.delete();
    iss_cyc.delete();
    got_c.delete();
    got_s.delete();
    pop_cyc.delete();
    returned = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ENABLE = 1'b0;
    PHASE_CLR = 1'b0;
    FREQ_LOAD = 1'b0;
    inj = 1'b0;
    CORD_DOUT_VALID = 1'b0;
    clear_logs();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic load_freq(logic [31:0] f);
    FREQ_WORD = f;
    FREQ_LOAD = 1'b1;
    cycle();
    FREQ_LOAD = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ENABLE = 1'b0;
    rdy_mode = 1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (DRAINED === 1'b1 && core_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    CORD_RFD = 1'b1;
    #1;
    checks++; if (CORD_DIN_VALID !== 1'b0) begin errors++; $display("FAIL rst_din_valid got %b want 0", CORD_DIN_VALID); end
    checks++; if (CORD_DIN_A !== 32'h0) begin errors++; $display("FAIL rst_din_a got %h want 0", CORD_DIN_A); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", OUT_VALID); end
    checks++; if (OUT_COS !== 32'h0) begin errors++; $display("FAIL rst_out_cos got %h want 0", OUT_COS); end
    checks++; if (OUT_SIN !== 32'h0) begin errors++; $display("FAIL rst_out_sin got %h want 0", OUT_SIN); end
    checks++; if (INFLIGHT !== 5'd0) begin errors++; $display("FAIL rst_inflight got %0d want 0", INFLIGHT); end
    checks++; if (DRAINED !== 1'b1) begin errors++; $display("FAIL rst_drained got %b want 1", DRAINED); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", ERR); end
  endtask

  task automatic test_nco_sweep();
    logic [31:0] sweep [4];
    logic [31:0] cos_exp [4];
    logic [31:0] e;
    bit ok;
    sweep   = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
    cos_exp = '{32'h3FFF_FFFF, 32'h0000_0000, 32'hC000_0001, 32'h0000_0000};
    do_reset();
    lat = 6; rfd_mode = 0; rdy_mode = 1; PHASE_OFFSET = '0;
    load_freq(32'h4000_0000);
    ENABLE = 1'b1;
    cycle();
    checks++; if (iss_ang.size() != 0) begin errors++; $display("FAIL nco_first_issue_early got %0d issues want 0", iss_ang.size()); end
    cycle();
    checks++; if (iss_ang.size() != 1) begin errors++; $display("FAIL nco_first_issue got %0d issues want 1", iss_ang.size()); end
    repeat (10) cycle();
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL nco_drain got timeout want drained"); end
    checks++; if (iss_ang.size() != 12) begin errors++; $display("FAIL nco_issue_count got %0d want 12", iss_ang.size()); end
    for (int k = 0; k < 5 && k < iss_ang.size(); k++) begin
      e = sweep[k % 4];
      checks++; if (iss_ang[k] !== e) begin errors++; $display("FAIL nco_angle[%0d] got %h want %h", k, iss_ang[k], e); end
    end
    checks++; if (got_c.size() != 12) begin errors++; $display("FAIL nco_result_count got %0d want 12", got_c.size()); end
    for (int k = 0; k < 4 && k < got_c.size(); k++) begin
      checks++; if (got_c[k] !== cos_exp[k]) begin errors++; $display("FAIL nco_cos[%0d] got %h want %h", k, got_c[k], cos_exp[k]); end
    end
    for (int k = 0; k < got_s.size(); k++) begin
      e = sinv(nco(32'h0, 32'h4000_0000, k));
      checks++; if (got_s[k] !== e) begin errors++; $display("FAIL nco_sin[%0d] got %h want %h", k, got_s[k], e); end
    end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL nco_err got %b want 0", ERR); end
  endtask

  task automatic test_backpressure();
    logic [31:0] f, off, e;
    bit ok;
    do_reset();
    lat = 48; rfd_mode = 0; rdy_mode = 0;
    off = $urandom; f = $urandom;
    PHASE_OFFSET = off;
    load_freq(f);
    ENABLE = 1'b1;
    repeat (30) cycle();
    checks++; if (INFLIGHT !== 5'(16 - returned)) begin errors++; $display("FAIL bp_inflight_mid got %0d want %0d", INFLIGHT, 16 - returned); end
    repeat (70) cycle();
    checks++; if (iss_ang.size() != 16) begin errors++; $display("FAIL bp_issue_count got %0d want 16", iss_ang.size()); end
    checks++; if (CORD_DIN_VALID !== 1'b0) begin errors++; $display("FAIL bp_stalled got %b want 0", CORD_DIN_VALID); end
    checks++; if (INFLIGHT !== 5'(iss_ang.size() - returned)) begin errors++; $display("FAIL bp_inflight got %0d want %0d", INFLIGHT, iss_ang.size() - returned); end
    checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", OUT_VALID); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL bp_err got %b want 0", ERR); end
    rdy_mode = 1;
    repeat (5) cycle();
    checks++;
    if (pop_cyc.size() == 0 || iss_cyc.size() < 17) begin
      errors++; $display("FAIL bp_resume got pops=%0d issues=%0d want resume", pop_cyc.size(), iss_cyc.size());
    end else if (iss_cyc[16] != pop_cyc[0] + 1) begin
      errors++; $display("FAIL bp_resume_cycle got %0d want %0d", iss_cyc[16], pop_cyc[0] + 1);
    end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain got timeout want drained"); end
    checks++; if (got_c.size() != iss_ang.size()) begin errors++; $display("FAIL bp_result_count got %0d want %0d", got_c.size(), iss_ang.size()); end
    for (int k = 0; k < iss_ang.size(); k++) begin
      e = nco(off, f, k);
      checks++; if (iss_ang[k] !== e) begin errors++; $display("FAIL bp_angle[%0d] got %h want %h", k, iss_ang[k], e); end
      if (k < got_c.size()) begin
        checks++; if (got_c[k] !== cosv(e)) begin errors++; $display("FAIL bp_cos[%0d] got %h want %h", k, got_c[k], cosv(e)); end
      end
    end
  endtask

  task automatic test_rfd_gaps();
    logic [31:0] f, off, e;
    int bad;
    bit ok;
    do_reset();
    lat = $urandom_range(3, 20); rfd_mode = 1; rdy_mode = 2;
    off = $urandom; f = $urandom;
    PHASE_OFFSET = off;
    load_freq(f);
    ENABLE = 1'b1;
    repeat (80) cycle();
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL gap_drain got timeout want drained"); end
    checks++; if (iss_ang.size() < 10) begin errors++; $display("FAIL gap_issue_count got %0d want >=10", iss_ang.size()); end
    bad = 0;
    foreach (iss_cyc[k]) if (iss_cyc[k] % 4 != 0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL gap_issue_without_rfd got %0d want 0", bad); end
    checks++; if (got_c.size() != iss_ang.size()) begin errors++; $display("FAIL gap_result_count got %0d want %0d", got_c.size(), iss_ang.size()); end
    for (int k = 0; k < iss_ang.size(); k++) begin
      e = nco(off, f, k);
      checks++; if (iss_ang[k] !== e) begin errors++; $display("FAIL gap_angle[%0d] got %h want %h", k, iss_ang[k], e); end
      if (k < got_c.size()) begin
        checks++; if (got_s[k] !== sinv(e)) begin errors++; $display("FAIL gap_sin[%0d] got %h want %h", k, got_s[k], sinv(e)); end
      end
    end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL gap_err got %b want 0", ERR); end
  endtask

  task automatic test_phase_clr();
    logic [31:0] f;
    logic [31:0] exp_a [7];
    bit ok;
    do_reset();
    lat = 4; rfd_mode = 2; rfd_man = 1'b0; rdy_mode = 1; PHASE_OFFSET = '0;
    load_freq(32'h1000_0000);
    ENABLE = 1'b1;
    cycle();
    rfd_man = 1'b1;
    repeat (3) cycle();
    rfd_man = 1'b0;
    f = $urandom | 32'h1;
    load_freq(f);
    rfd_man = 1'b1;
    PHASE_CLR = 1'b1;
    cycle();
    PHASE_CLR = 1'b0;
    repeat (3) cycle();
    rfd_man = 1'b0;
    drain(ok);
    exp_a = '{32'h0, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h0, f, f + f};
    checks++; if (!ok) begin errors++; $display("FAIL clr_drain got timeout want drained"); end
    checks++; if (iss_ang.size() != 7) begin errors++; $display("FAIL clr_issue_count got %0d want 7", iss_ang.size()); end
    for (int k = 0; k < 7 && k < iss_ang.size(); k++) begin
      checks++; if (iss_ang[k] !== exp_a[k]) begin errors++; $display("FAIL clr_angle[%0d] got %h want %h", k, iss_ang[k], exp_a[k]); end
    end
  endtask

  task automatic test_err();
    do_reset();
    rfd_mode = 2; rfd_man = 1'b0; rdy_mode = 0;
    cycle();
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", ERR); end
    inj = 1'b1;
    cycle();
    inj = 1'b0;
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", ERR); end
    checks++; if (INFLIGHT !== 5'd0) begin errors++; $display("FAIL err_inflight got %0d want 0", INFLIGHT); end
    repeat (10) cycle();
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", ERR); end
    do_reset();
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL err_rst got %b want 0", ERR); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    lat = 10; rfd_mode = 2; rfd_man = 1'b1; rdy_mode = 0;
    load_freq($urandom);
    ENABLE = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (iss_ang.size() >= 8) rfd_man = 1'b0;
      if (returned >= 3) break;
    end
    checks++; if (INFLIGHT !== 5'd5) begin errors++; $display("FAIL mid_inflight_pre got %0d want 5", INFLIGHT); end
    checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL mid_out_valid_pre got %b want 1", OUT_VALID); end
    RST = 1'b1;
    rfd_man = 1'b1;
    core_q.delete();
    cycle();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", OUT_VALID); end
    checks++; if (INFLIGHT !== 5'd0) begin errors++; $display("FAIL mid_inflight got %0d want 0", INFLIGHT); end
    checks++; if (DRAINED !== 1'b1) begin errors++; $display("FAIL mid_drained got %b want 1", DRAINED); end
    checks++; if (CORD_DIN_VALID !== 1'b0) begin errors++; $display("FAIL mid_din_valid got %b want 0", CORD_DIN_VALID); end
    ENABLE = 1'b0;
    rfd_man = 1'b0;
    RST = 1'b0;
    cycle();
  endtask

  initial begin
    RST = 1'b1; ENABLE = 1'b0; FREQ_LOAD = 1'b0; PHASE_CLR = 1'b0;
    FREQ_WORD = '0; PHASE_OFFSET = '0; CORD_RFD = 1'b0; CORD_DOUT_VALID = 1'b0;
    CORD_DOUT_X = '0; CORD_DOUT_Y = '0; OUT_READY = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    test_reset();
    test_nco_sweep();
    test_backpressure();
    test_rfd_gaps();
    test_phase_clr();
    test_err();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
